// File: rtl/uio_arbiter_if.sv
// Bundle of request, grant and pad signals shared by two requesters
// and the uio arbiter. The arbiter takes the slave side; whatever drives
// requests and pads (a bench or the surrounding chip) takes the master side.
interface uio_arbiter_if;
  logic [1:0] req_i;
  logic [1:0] we_i;
  logic [7:0] wdata0_i;
  logic [7:0] wdata1_i;
  logic [1:0] gnt_o;
  logic [1:0] valid_o;
  logic [7:0] rdata_o;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic       busy_o;

  modport slave (
    input  req_i,
    input  we_i,
    input  wdata0_i,
    input  wdata1_i,
    input  uio_in,
    output gnt_o,
    output valid_o,
    output rdata_o,
    output uio_out,
    output uio_oe,
    output busy_o
  );

  modport master (
    output req_i,
    output we_i,
    output wdata0_i,
    output wdata1_i,
    output uio_in,
    input  gnt_o,
    input  valid_o,
    input  rdata_o,
    input  uio_out,
    input  uio_oe,
    input  busy_o
  );
endinterface

// File: rtl/uio_arbiter.sv
// Two-requester round-robin arbiter for the shared 8-bit uio pad bus.
// Every ownership change passes through a one-cycle turnaround with the
// pads released, a grant lasts until the owner stops requesting or has
// taken MAX_BURST beats, and the transfer direction is frozen when the
// owner is chosen.
module uio_arbiter #(
  parameter int unsigned MAX_BURST = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          ena,
  uio_arbiter_if.slave  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] TURN  = 2'd1;
  localparam logic [1:0] GRANT = 2'd2;

  localparam logic [8:0] BURST_LIMIT = 9'(MAX_BURST);

  logic [1:0] state_q, state_d;
  logic       owner_q, owner_d;
  logic       dir_q,   dir_d;
  logic       ptr_q,   ptr_d;
  logic [7:0] cnt_q,   cnt_d;
  logic [7:0] rdata_q, rdata_d;

  logic inGrant;
  logic ownerReq;
  logic otherReq;
  logic beat;
  logic writeBeat;
  logic lastBeat;
  logic relGrant;
  logic idlePick;

  // Qualify the current cycle: is the owner taking a beat, and does the grant end here
  always_comb begin
    inGrant   = (state_q == GRANT);
    ownerReq  = bus.req_i[owner_q];
    otherReq  = bus.req_i[~owner_q];
    beat      = inGrant && ena && ownerReq;
    writeBeat = beat && dir_q;
    lastBeat  = beat && (({1'b0, cnt_q} + 9'd1) == BURST_LIMIT);
    relGrant  = inGrant && ena && (!ownerReq || lastBeat);
    idlePick  = bus.req_i[ptr_q] ? ptr_q : ~ptr_q;
  end

  // Next-state logic: owner selection, turnaround, burst counting and release
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    dir_d   = dir_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    if (!ena) begin
      state_d = IDLE;
      cnt_d   = 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_i != 2'b00) begin
            owner_d = idlePick;
            dir_d   = bus.we_i[idlePick];
            state_d = TURN;
          end
        end
        TURN: begin
          state_d = GRANT;
        end
        GRANT: begin
          if (beat) begin
            cnt_d = cnt_q + 8'd1;
            if (!dir_q) begin
              rdata_d = bus.uio_in;
            end
          end
          if (relGrant) begin
            cnt_d = 8'd0;
            ptr_d = ~owner_q;
            if (otherReq) begin
              owner_d = ~owner_q;
              dir_d   = bus.we_i[~owner_q];
              state_d = TURN;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State registers; reset drops to IDLE at once so the pads are released without a clock
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      dir_q   <= 1'b0;
      ptr_q   <= 1'b0;
      cnt_q   <= 8'd0;
      rdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      dir_q   <= dir_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Output decode: grant from registered state, strobes and pad drive from the live beat
  always_comb begin
    bus.gnt_o   = inGrant ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    bus.valid_o = beat ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    bus.uio_oe  = writeBeat ? 8'hFF : 8'h00;
    bus.uio_out = writeBeat ? (owner_q ? bus.wdata1_i : bus.wdata0_i) : 8'h00;
    bus.rdata_o = rdata_q;
    bus.busy_o  = (state_q != IDLE);
  end

  // Structural invariants of the arbiter outputs
  property pGntOneHot;
    @(posedge clk_i) disable iff (!rst_ni) $onehot0(bus.gnt_o);
  endproperty
  property pValidInsideGrant;
    @(posedge clk_i) disable iff (!rst_ni) (bus.valid_o & ~bus.gnt_o) == 2'b00;
  endproperty
  property pOeAllOrNothing;
    @(posedge clk_i) disable iff (!rst_ni) (bus.uio_oe == 8'hFF) || (bus.uio_oe == 8'h00);
  endproperty
  property pLegalState;
    @(posedge clk_i) disable iff (!rst_ni) state_q != 2'd3;
  endproperty

  aGntOneHot:        assert property (pGntOneHot);
  aValidInsideGrant: assert property (pValidInsideGrant);
  aOeAllOrNothing:   assert property (pOeAllOrNothing);
  aLegalState:       assert property (pLegalState);

endmodule

// File: tb/tb_uio_arbiter.sv
// Self-checking bench for uio_arbiter: a spec-level model checked every cycle
// plus directed scenarios with hand-computed expectations.
module tb_uio_arbiter;

  localparam int MAX_BURST = 8;

  localparam int PH_IDLE  = 0;
  localparam int PH_TURN  = 1;
  localparam int PH_GRANT = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic ena   = 1'b0;

  uio_arbiter_if bus();

  uio_arbiter #(.MAX_BURST(MAX_BURST)) dut (
    .clk_i  (clock),
    .rst_ni (~reset),
    .ena    (ena),
    .bus    (bus)
  );

  // Free-running clock, period 10
  always #5 clock = ~clock;

  int checkCount = 0;
  int failCount  = 0;

  int         mPhase;
  int         mOwner;
  int         mDir;
  int         mPtr;
  int         mBeats;
  logic [7:0] mRdata;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [1:0] req, input logic [1:0] we,
                               input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] uin);
    ena          = en;
    bus.req_i    = req;
    bus.we_i     = we;
    bus.wdata0_i = w0;
    bus.wdata1_i = w1;
    bus.uio_in   = uin;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [1:0] oneHot(input int o);
    return (o == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic modelReset();
    mPhase = PH_IDLE;
    mOwner = 0;
    mDir   = 0;
    mPtr   = 0;
    mBeats = 0;
    mRdata = 8'h00;
  endtask

  // Model follows reset immediately, even between clock edges
  always @(posedge reset) modelReset();

  // Compare process: outputs against the model on every falling edge, then advance the model
  always @(negedge clock) begin
    logic       isBeat;
    logic [1:0] eGnt, eValid;
    logic [7:0] eOe, eOut;
    int         other;
    if (reset) begin
      modelReset();
      checkOutput("rstGnt",   32'(bus.gnt_o),   32'h0);
      checkOutput("rstValid", 32'(bus.valid_o), 32'h0);
      checkOutput("rstOe",    32'(bus.uio_oe),  32'h0);
      checkOutput("rstOut",   32'(bus.uio_out), 32'h0);
      checkOutput("rstRdata", 32'(bus.rdata_o), 32'h0);
      checkOutput("rstBusy",  32'(bus.busy_o),  32'h0);
    end else begin
      isBeat = (mPhase == PH_GRANT) && ena && bus.req_i[mOwner];
      eGnt   = (mPhase == PH_GRANT) ? oneHot(mOwner) : 2'b00;
      eValid = isBeat ? oneHot(mOwner) : 2'b00;
      eOe    = (isBeat && mDir == 1) ? 8'hFF : 8'h00;
      eOut   = (isBeat && mDir == 1) ? ((mOwner == 0) ? bus.wdata0_i : bus.wdata1_i) : 8'h00;
      checkOutput("modelGnt",   32'(bus.gnt_o),   32'(eGnt));
      checkOutput("modelValid", 32'(bus.valid_o), 32'(eValid));
      checkOutput("modelOe",    32'(bus.uio_oe),  32'(eOe));
      checkOutput("modelOut",   32'(bus.uio_out), 32'(eOut));
      checkOutput("modelRdata", 32'(bus.rdata_o), 32'(mRdata));
      checkOutput("modelBusy",  32'(bus.busy_o),  32'(mPhase != PH_IDLE));
      if (!ena) begin
        mPhase = PH_IDLE;
        mBeats = 0;
      end else if (mPhase == PH_IDLE) begin
        if (bus.req_i != 2'b00) begin
          mOwner = bus.req_i[mPtr] ? mPtr : 1 - mPtr;
          mDir   = int'(bus.we_i[mOwner]);
          mPhase = PH_TURN;
        end
      end else if (mPhase == PH_TURN) begin
        mPhase = PH_GRANT;
      end else begin
        if (isBeat) begin
          mBeats++;
          if (mDir == 0) mRdata = bus.uio_in;
        end
        if (!bus.req_i[mOwner] || mBeats == MAX_BURST) begin
          mBeats = 0;
          other  = 1 - mOwner;
          mPtr   = other;
          if (bus.req_i[other]) begin
            mOwner = other;
            mDir   = int'(bus.we_i[other]);
            mPhase = PH_TURN;
          end else begin
            mPhase = PH_IDLE;
          end
        end
      end
    end
  end

  // Expected grant k cycles after both requesters start asking from reset
  function automatic logic [1:0] contentionGnt(input int k);
    if (k == 1 || k == 10 || k == 19) return 2'b00;
    if (k <= 9 || k == 20) return 2'b01;
    return 2'b10;
  endfunction

  // Expected grant k cycles after requester 0 alone starts a long request
  function automatic logic [1:0] burstGnt(input int k);
    if ((k >= 2 && k <= 9) || (k >= 12 && k <= 19)) return 2'b01;
    return 2'b00;
  endfunction

  task automatic resetPulse();
    tick();
    reset = 1'b1;
    applyStimulus(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00);
    tick();
    reset = 1'b0;
  endtask

  initial begin
    modelReset();
    applyStimulus(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00);
    repeat (2) tick();
    checkOutput("resetGnt",  32'(bus.gnt_o),  32'h0);
    checkOutput("resetOe",   32'(bus.uio_oe), 32'h0);
    checkOutput("resetBusy", 32'(bus.busy_o), 32'h0);

    // Single write by requester 0, direction flip ignored mid-grant
    reset = 1'b0;
    applyStimulus(1'b1, 2'b01, 2'b01, 8'hA5, 8'h00, 8'h00);
    tick();
    checkOutput("wrTurnBusy", 32'(bus.busy_o), 32'h1);
    checkOutput("wrTurnGnt",  32'(bus.gnt_o),  32'h0);
    checkOutput("wrTurnOe",   32'(bus.uio_oe), 32'h0);
    tick();
    applyStimulus(1'b1, 2'b01, 2'b00, 8'hA5, 8'h00, 8'h00);
    #1;
    for (int b = 1; b <= 3; b++) begin
      checkOutput("wrBeatGnt",   32'(bus.gnt_o),   32'h1);
      checkOutput("wrBeatValid", 32'(bus.valid_o), 32'h1);
      checkOutput("wrBeatOe",    32'(bus.uio_oe),  32'hFF);
      checkOutput("wrBeatOut",   32'(bus.uio_out), 32'hA5);
      if (b < 3) tick();
    end
    tick();
    bus.req_i = 2'b00;
    #1;
    checkOutput("wrDropGnt",   32'(bus.gnt_o),   32'h1);
    checkOutput("wrDropValid", 32'(bus.valid_o), 32'h0);
    checkOutput("wrDropOe",    32'(bus.uio_oe),  32'h0);
    checkOutput("wrDropOut",   32'(bus.uio_out), 32'h0);
    tick();
    checkOutput("wrIdleBusy", 32'(bus.busy_o), 32'h0);

    // Single read by requester 1
    applyStimulus(1'b1, 2'b10, 2'b00, 8'h00, 8'h00, 8'h3C);
    tick();
    checkOutput("rdTurnOe", 32'(bus.uio_oe), 32'h0);
    tick();
    checkOutput("rdBeatGnt",   32'(bus.gnt_o),   32'h2);
    checkOutput("rdBeatValid", 32'(bus.valid_o), 32'h2);
    checkOutput("rdBeatOe",    32'(bus.uio_oe),  32'h0);
    tick();
    applyStimulus(1'b1, 2'b00, 2'b00, 8'h00, 8'h00, 8'h55);
    #1;
    checkOutput("rdData",  32'(bus.rdata_o), 32'h3C);
    checkOutput("rdOe",    32'(bus.uio_oe),  32'h0);
    tick();
    checkOutput("rdHold",  32'(bus.rdata_o), 32'h3C);
    checkOutput("rdIdle",  32'(bus.busy_o),  32'h0);

    // Contention from reset: alternating 8-beat bursts with a turnaround between
    resetPulse();
    applyStimulus(1'b1, 2'b11, 2'b11, 8'h11, 8'h22, 8'h00);
    for (int k = 1; k <= 20; k++) begin
      tick();
      checkOutput($sformatf("contGnt%0d", k), 32'(bus.gnt_o), 32'(contentionGnt(k)));
      if (k == 2)  checkOutput("contOut0", 32'(bus.uio_out), 32'h11);
      if (k == 11) checkOutput("contOut1", 32'(bus.uio_out), 32'h22);
    end
    bus.req_i = 2'b00;
    repeat (2) tick();

    // Burst cap: lone requester released after 8 beats, then re-granted
    resetPulse();
    applyStimulus(1'b1, 2'b01, 2'b01, 8'h5A, 8'h00, 8'h00);
    for (int k = 1; k <= 20; k++) begin
      tick();
      checkOutput($sformatf("capGnt%0d", k), 32'(bus.gnt_o), 32'(burstGnt(k)));
      if (k == 10) checkOutput("capIdleBusy", 32'(bus.busy_o), 32'h0);
      if (k == 11) checkOutput("capTurnBusy", 32'(bus.busy_o), 32'h1);
    end
    bus.req_i = 2'b00;
    repeat (2) tick();

    // Abort: ena dropped in beat 3, pointer must stay on requester 0
    resetPulse();
    applyStimulus(1'b1, 2'b01, 2'b01, 8'hC3, 8'h00, 8'h00);
    repeat (3) tick();
    tick();
    ena = 1'b0;
    #1;
    checkOutput("abortOe",    32'(bus.uio_oe),  32'h0);
    checkOutput("abortValid", 32'(bus.valid_o), 32'h0);
    checkOutput("abortOut",   32'(bus.uio_out), 32'h0);
    tick();
    checkOutput("abortGnt",  32'(bus.gnt_o),  32'h0);
    checkOutput("abortBusy", 32'(bus.busy_o), 32'h0);
    applyStimulus(1'b1, 2'b11, 2'b00, 8'h00, 8'h00, 8'h00);
    repeat (2) tick();
    checkOutput("abortPtrGnt", 32'(bus.gnt_o), 32'h1);
    bus.req_i = 2'b00;
    repeat (2) tick();

    // Asynchronous reset in the middle of a requester-1 write
    applyStimulus(1'b1, 2'b10, 2'b10, 8'h00, 8'h99, 8'h00);
    repeat (2) tick();
    checkOutput("arstPreOe",  32'(bus.uio_oe),  32'hFF);
    checkOutput("arstPreOut", 32'(bus.uio_out), 32'h99);
    tick();
    #2;
    reset = 1'b1;
    #1;
    checkOutput("arstOe",    32'(bus.uio_oe),  32'h0);
    checkOutput("arstGnt",   32'(bus.gnt_o),   32'h0);
    checkOutput("arstValid", 32'(bus.valid_o), 32'h0);
    checkOutput("arstOut",   32'(bus.uio_out), 32'h0);
    tick();
    reset = 1'b0;
    applyStimulus(1'b1, 2'b11, 2'b11, 8'h01, 8'h02, 8'h00);
    repeat (2) tick();
    checkOutput("arstPtrGnt", 32'(bus.gnt_o), 32'h1);
    bus.req_i = 2'b00;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
